// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser, shared sample-tick prescaler and per-bit
// stability counters producing a pressed-high level plus one-cycle press/release strobes.
module button_debounce #(
   parameter int WIDTH        = 8,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_stable,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release,
   output logic             sample_tick
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q, pressed;
   logic [PW-1:0]    pre_q, pre_d;
   logic             run_q, tick;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] stable_q, stable_d, press_q, release_q;

   assign pressed = sync2_q ^ {WIDTH{ACTIVE_LOW}};
   // run_q keeps a TICK_DIV of 1 from ticking while reset is still held
   assign tick    = run_q && (pre_q == PRE_LAST);
   assign pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < WIDTH; i++)
         if (tick) begin
            if (pressed[i] == stable_q[i])
               cnt_d[i] = '0;
            else if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = pressed[i];
               cnt_d[i]    = '0;
            end else
               cnt_d[i] = cnt_q[i] + CW'(1);
         end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync1_q   <= {WIDTH{ACTIVE_LOW}};
         sync2_q   <= {WIDTH{ACTIVE_LOW}};
         pre_q     <= '0;
         run_q     <= 1'b0;
         cnt_q     <= '{default: '0};
         stable_q  <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         pre_q     <= pre_d;
         run_q     <= 1'b1;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         press_q   <= stable_d & ~stable_q;
         release_q <= stable_q & ~stable_d;
      end

   assign btn_stable  = stable_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign sample_tick = tick;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: table-driven segments, hand corner cases and random stimulus
// checked every cycle against a tick-sample-history reference model.
module tb_button_debounce;
   localparam int W  = 8;
   localparam int TD = 4;
   localparam int ST = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] btn_raw;
   logic [W-1:0] btn_stable, btn_press, btn_release;
   logic         sample_tick;

   button_debounce #(.WIDTH(W), .ACTIVE_LOW(1'b1), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_stable(btn_stable),
      .btn_press(btn_press), .btn_release(btn_release), .sample_tick(sample_tick)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   // reference model: stable flips when the last ST tick samples all disagree with it
   int           e;
   logic [W-1:0] m_s1, m_s2, m_stable, m_press, m_rel;
   logic         m_tick;
   logic [W-1:0] samples[$];

   typedef struct {
      logic [W-1:0] raw;
      int           hold;
      logic [W-1:0] exp_stable;
      logic [W-1:0] exp_press;
      logic [W-1:0] exp_rel;
      int           exp_press_cyc;
      int           exp_rel_cyc;
      int           exp_ticks;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      e = 0;
      m_s1 = '0;
      m_s2 = '0;
      m_stable = '0;
      m_press = '0;
      m_rel = '0;
      m_tick = 1'b0;
      samples.delete();
   endtask

   task automatic model_edge(input logic [W-1:0] raw);
      logic [W-1:0] old;
      old = m_stable;
      if (e % TD == TD - 1) begin
         samples.push_back(m_s2);
         if (samples.size() > ST) void'(samples.pop_front());
         if (samples.size() == ST)
            for (int i = 0; i < W; i++) begin
               bit all;
               all = 1'b1;
               for (int k = 0; k < ST; k++) if (samples[k][i] == m_stable[i]) all = 1'b0;
               if (all) m_stable[i] = ~m_stable[i];
            end
      end
      m_s2 = m_s1;
      m_s1 = ~raw;
      e++;
      m_press = m_stable & ~old;
      m_rel = old & ~m_stable;
      m_tick = (e % TD == TD - 1);
   endtask

   // entered and left at a negedge
   task automatic step(input logic [W-1:0] raw);
      btn_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
      chk("cycle", {btn_stable, btn_press, btn_release, 7'd0, sample_tick},
          {m_stable, m_press, m_rel, 7'd0, m_tick});
      @(negedge clk);
   endtask

   task automatic hold_reset(input logic [W-1:0] raw, input int n);
      reset = 1'b0;
      btn_raw = raw;
      model_reset();
      #1;
      chk("reset_async", {btn_stable, btn_press, btn_release, 7'd0, sample_tick}, 32'd0);
      @(negedge clk);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         chk("reset_hold", {btn_stable, btn_press, btn_release, 7'd0, sample_tick}, 32'd0);
         @(negedge clk);
      end
      reset = 1'b1;
   endtask

   initial begin
      logic [W-1:0] acc_stable, acc_press, acc_rel, raw;
      int pc, rc, tc, first;
      tbl[0] = '{8'hFF, 100, 8'h00, 8'h00, 8'h00, 0, 0, 25};
      tbl[1] = '{8'hFE, 16,  8'h01, 8'h01, 8'h00, 1, 0, 4};
      tbl[2] = '{8'hFF, 16,  8'h00, 8'h00, 8'h01, 0, 1, 4};
      tbl[3] = '{8'h8F, 16,  8'h70, 8'h70, 8'h00, 1, 0, 4};
      tbl[4] = '{8'hFF, 16,  8'h00, 8'h00, 8'h70, 0, 1, 4};
      reset = 1'b0;
      btn_raw = 8'h00;
      model_reset();
      @(negedge clk);
      hold_reset(8'h00, 3);
      for (int v = 0; v < 5; v++) begin
         acc_press = '0;
         acc_rel = '0;
         pc = 0;
         rc = 0;
         tc = 0;
         for (int c = 0; c < tbl[v].hold; c++) begin
            btn_raw = tbl[v].raw;
            @(posedge clk);
            model_edge(tbl[v].raw);
            #1;
            chk("cycle", {btn_stable, btn_press, btn_release, 7'd0, sample_tick},
                {m_stable, m_press, m_rel, 7'd0, m_tick});
            acc_press |= btn_press;
            acc_rel |= btn_release;
            pc += (btn_press != 0) ? 1 : 0;
            rc += (btn_release != 0) ? 1 : 0;
            tc += sample_tick ? 1 : 0;
            @(negedge clk);
         end
         chk($sformatf("tbl%0d_stable", v), {24'd0, btn_stable}, {24'd0, tbl[v].exp_stable});
         chk($sformatf("tbl%0d_press", v), {24'd0, acc_press}, {24'd0, tbl[v].exp_press});
         chk($sformatf("tbl%0d_release", v), {24'd0, acc_rel}, {24'd0, tbl[v].exp_rel});
         chk($sformatf("tbl%0d_press_cycles", v), pc, tbl[v].exp_press_cyc);
         chk($sformatf("tbl%0d_release_cycles", v), rc, tbl[v].exp_rel_cyc);
         chk($sformatf("tbl%0d_ticks", v), tc, tbl[v].exp_ticks);
      end
      // bounce on bit 3: two ticks low, one tick high, never three consecutive
      acc_stable = '0;
      pc = 0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 2 * TD; c++) begin
            step(8'hF7);
            acc_stable |= btn_stable;
            pc += ((btn_press | btn_release) != 0) ? 1 : 0;
         end
         for (int c = 0; c < TD; c++) begin
            step(8'hFF);
            acc_stable |= btn_stable;
            pc += ((btn_press | btn_release) != 0) ? 1 : 0;
         end
      end
      for (int c = 0; c < 16; c++) begin
         step(8'hFF);
         acc_stable |= btn_stable;
         pc += ((btn_press | btn_release) != 0) ? 1 : 0;
      end
      chk("bounce_stable", {24'd0, acc_stable}, 32'd0);
      chk("bounce_strobes", pc, 0);
      // one-clock glitches on bit 7
      acc_stable = '0;
      for (int c = 0; c < 60; c++) begin
         step((c % 5 == 0) ? 8'h7F : 8'hFF);
         acc_stable |= btn_stable;
      end
      for (int c = 0; c < 16; c++) step(8'hFF);
      chk("glitch_stable7", {31'd0, acc_stable[7]}, 32'd0);
      // reset mid-count with bit 5 held pressed
      for (int c = 0; c < 2 * TD; c++) step(8'hDF);
      chk("midrst_pre", {24'd0, btn_stable}, 32'd0);
      hold_reset(8'hDF, 2);
      chk("midrst_release", {24'd0, btn_stable}, 32'd0);
      first = -1;
      for (int c = 1; c <= 20; c++) begin
         step(8'hDF);
         if (first < 0 && btn_press[5]) first = c;
      end
      chk("midrst_press_cycle", first, ST * TD);
      chk("midrst_stable", {24'd0, btn_stable}, 32'h20);
      // random slow-changing pins with occasional reset
      raw = 8'hFF;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(299) == 0) hold_reset(raw, 1);
         for (int i = 0; i < W; i++) if ($urandom_range(19) == 0) raw[i] = ~raw[i];
         step(raw);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
